mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-requestor arbiter that multiplexes cache line-fill and write-back traffic onto the single synchronous memory port.
- Generalises the fixed 3-channel (I-read, D-read, D-write) arbiter to NUM_PORTS generic read/write requestors.
- Uses round-robin fairness, registered memory-side outputs and an optional per-transaction timeout.
- Sits between the I-/D-caches (and future requestors such as a prefetcher) and the memory model.

Parameters:
- NUM_PORTS, 3, number of requestor ports (≥2).
- ADDR_W, 32, address width.
- DATA_W, 128, memory transfer width (one cache line).
- TIMEOUT, 255, cycles allowed for mem_ack before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-port request, level held until ack.
- req_rw  in  NUM_PORTS  per-port direction: 1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  flattened per-port address; port i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  flattened per-port write data.
- ack  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  shared read-return bus; valid only while the matching ack bit is high.
- err  out  NUM_PORTS  one-hot, one-cycle timeout pulse (tied 0 without ARB_TIMEOUT_EN).
- mem_enable  out  1  memory request.
- mem_rw  out  1  memory direction: 1 = write.
- mem_ack  in  1  memory completion.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  write data driven to memory.
- mem_data_out  in  DATA_W  read data returned from memory.

Behaviour:
- Reset state: every output is 0; state = IDLE; last_grant = NUM_PORTS-1, so port 0 wins first. Asserting reset mid-transaction drops mem_enable immediately and no ack is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - When any req bit is high, select the winner as the first set bit scanning from (last_grant+1) mod NUM_PORTS upward, with wrap-around.
  - On that same edge, register mem_addr, mem_rw and mem_data_in from the winner's slice, set mem_enable=1, store the grant index in last_grant, and go to BUSY.
  - Latency: a req sampled at edge n gives mem_enable high after edge n.
- BUSY:
  - mem_enable, mem_rw, mem_addr and mem_data_in stay stable.
  - New requests are ignored.
  - On the edge where mem_ack=1:
    - mem_enable goes to 0.
    - ack[grant] goes to 1 for exactly one cycle.
    - For reads, rdata is loaded from mem_data_out; for writes, rdata holds its previous value.
    - State moves to DONE.
- DONE:
  - Lasts one cycle; ack returns to 0.
  - The granted requester must drop or change req in this cycle.
  - Move to IDLE.
  - The earliest next mem_enable comes 2 edges after the ack edge.
- mem_ack seen in IDLE or DONE is ignored.
- If a requester drops req during BUSY, the transaction still completes and ack is still pulsed.
- If a requester changes req_addr during BUSY, there is no effect; the latched values are used.
- With all NUM_PORTS requests held continuously, grants rotate 0,1,…,N-1,0. No port waits more than NUM_PORTS-1 transactions.
- ack, err and mem_enable are never high in the same cycle for different transactions.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT:
    - mem_enable goes to 0.
    - err[grant] goes to 1 for one cycle; ack stays 0 and rdata is unchanged.
    - State moves to DONE.
  - If mem_ack and the timeout occur on the same cycle, mem_ack wins: ack is pulsed, not err.
- When undefined:
  - No counter exists and err is constant 0.
  - BUSY waits indefinitely for mem_ack.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - an index-width constant function (clog2);
  - the RW_READ/RW_WRITE constants.
- One natural sub-module, rr_picker:
  - combinational;
  - inputs: req vector, last_grant;
  - outputs: valid, grant index.
  - The FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- Single read: port 1 req, req_rw=0, addr 0x0000_1040; mem_ack 3 cycles after mem_enable with mem_data_out=128'hA5… → mem_addr=0x1040 and mem_rw=0 stable throughout; ack=3'b010 for 1 cycle; rdata=128'hA5….
- Write: port 2 req_rw=1, wdata=128'hDEAD_BEEF… → mem_rw=1, mem_data_in matches, ack=3'b100; rdata unchanged.
- Fairness: all 3 ports held high, mem_ack 1 cycle after each enable → grant order 0,1,2,0,1,2; ≥2-cycle gap between mem_enable pulses.
- Mid-transaction change: port 0 granted, then its addr is changed and port 1 asserted during BUSY → mem_addr unchanged; port 1 served next.
- Reset: assert reset in BUSY → mem_enable and ack drop immediately; after release, port 0 has priority again.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): mem_ack never arrives → err[grant] pulses 8 cycles after entry to BUSY; ack stays 0; the arbiter then serves the next port.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding, direction constants and sizing helper
// for the N-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Bits needed to hold a port index; never less than one.
    function automatic int idx_w(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requestor and memory-side bundle of the arbiter.
// slave = arbiter view, master = environment (caches + memory) view.
interface mem_port_arbiter_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128
);

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        req_rw;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [NUM_PORTS-1:0]        err;

    logic                        mem_enable;
    logic                        mem_rw;
    logic                        mem_ack;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data_in;
    logic [DATA_W-1:0]           mem_data_out;

    modport slave (
        input  req, req_rw, req_addr, req_wdata,
        input  mem_ack, mem_data_out,
        output ack, rdata, err,
        output mem_enable, mem_rw, mem_addr, mem_data_in
    );

    modport master (
        output req, req_rw, req_addr, req_wdata,
        output mem_ack, mem_data_out,
        input  ack, rdata, err,
        input  mem_enable, mem_rw, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner select. Scans from
// last_grant+1 upward with wrap-around; lowest distance wins.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_grant
);

    // Walk farthest-to-nearest so the nearest set bit is written last.
    always_comb begin
        int w_idx;
        o_valid = 1'b0;
        o_grant = '0;
        w_idx   = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = (int'(i_last_grant) + k) % NUM_PORTS;
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_grant = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin N-port arbiter onto one memory port with
// registered memory-side outputs. Optional timeout: `define ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_PORTS);

    // The scan needs at least two ports and the abort needs a nonzero limit.
    if (NUM_PORTS < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("mem_port_arbiter: need NUM_PORTS >= 2 and TIMEOUT >= 1");
    end

    arb_state_e             r_state;
    arb_state_e             w_next;

    logic                   w_valid;
    logic [IDX_W-1:0]       w_grant;
    logic                   w_start;
    logic                   w_complete;
    logic                   w_abort;

    logic [IDX_W-1:0]       r_last_grant;
    logic                   r_mem_enable;
    logic                   r_mem_rw;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_data_in;
    logic [NUM_PORTS-1:0]   r_ack;
    logic [DATA_W-1:0]      r_rdata;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_req        (bus.req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_grant      (w_grant)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and per-edge strobes; mem_ack outside BUSY is ignored.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next  = BUSY;
                    w_start = 1'b1;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    w_next     = DONE;
                    w_complete = 1'b1;
                end else if (w_abort) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the winner's request; close it out on ack (reads return data).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant  <= IDX_W'(NUM_PORTS - 1);
            r_mem_enable  <= 1'b0;
            r_mem_rw      <= RW_READ;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_ack         <= '0;
            r_rdata       <= '0;
        end else begin
            r_ack <= '0;
            if (w_start) begin
                r_mem_enable  <= 1'b1;
                r_mem_rw      <= bus.req_rw[w_grant];
                r_mem_addr    <= bus.req_addr[int'(w_grant)*ADDR_W +: ADDR_W];
                r_mem_data_in <= bus.req_wdata[int'(w_grant)*DATA_W +: DATA_W];
                r_last_grant  <= w_grant;
            end
            if (w_complete) begin
                r_mem_enable        <= 1'b0;
                r_ack[r_last_grant] <= 1'b1;
                if (r_mem_rw == RW_READ) r_rdata <= bus.mem_data_out;
            end
            if (w_abort) begin
                r_mem_enable <= 1'b0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_PORTS-1:0] r_err;

    // Abort on the edge the counter would reach TIMEOUT; ack has priority.
    assign w_abort = (r_state == BUSY) && !bus.mem_ack &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

    // Count BUSY cycles spent waiting for mem_ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 r_cnt <= '0;
        else if (w_start)                          r_cnt <= '0;
        else if (r_state == BUSY && !bus.mem_ack)  r_cnt <= r_cnt + 1'b1;
    end

    // One-cycle error pulse to the port whose transaction was aborted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            r_err <= '0;
            if (w_abort) r_err[r_last_grant] <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_abort = 1'b0;
    assign bus.err = '0;
`endif

    assign bus.ack         = r_ack;
    assign bus.rdata       = r_rdata;
    assign bus.mem_enable  = r_mem_enable;
    assign bus.mem_rw      = r_mem_rw;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter (3 ports).
// Timeout steps compile in only with ARB_TIMEOUT_EN (TIMEOUT=8).
module tb_mem_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 128;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_dead;

    mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        bus.req_addr[p*AW +: AW] = a;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pat_a5   = {16{8'hA5}};
        pat_dead = {4{32'hDEAD_BEEF}};

        reset            = 1'b1;
        bus.req          = '0;
        bus.req_rw       = '0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_ack      = 1'b0;
        bus.mem_data_out = '0;

        // Reset state
        step();
        step();
        check("rst_en",    DW'(bus.mem_enable), 0);
        check("rst_ack",   DW'(bus.ack), 0);
        check("rst_err",   DW'(bus.err), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_addr",  DW'(bus.mem_addr), 0);
        reset = 1'b0;

        // Single read, port 1; ack three cycles after enable
        bus.req = 3'b010;
        set_addr(1, 32'h0000_1040);
        step();
        check("rd_en",   DW'(bus.mem_enable), 1);
        check("rd_addr", DW'(bus.mem_addr), 32'h1040);
        check("rd_rw",   DW'(bus.mem_rw), 0);
        step();
        check("rd_en_hold", DW'(bus.mem_enable), 1);
        step();
        check("rd_addr_hold", DW'(bus.mem_addr), 32'h1040);
        check("rd_no_ack",    DW'(bus.ack), 0);
        bus.mem_ack      = 1'b1;
        bus.mem_data_out = pat_a5;
        step();
        check("rd_ack",    DW'(bus.ack), 3'b010);
        check("rd_en_off", DW'(bus.mem_enable), 0);
        check("rd_rdata",  bus.rdata, pat_a5);
        bus.mem_ack = 1'b0;
        bus.req     = '0;
        step();
        check("rd_ack_1cyc", DW'(bus.ack), 0);

        // Write, port 2; rdata must keep the read value
        bus.req                     = 3'b100;
        bus.req_rw                  = 3'b100;
        bus.req_wdata[2*DW +: DW]   = pat_dead;
        set_addr(2, 32'h0000_2000);
        step();
        check("wr_en",   DW'(bus.mem_enable), 1);
        check("wr_rw",   DW'(bus.mem_rw), 1);
        check("wr_data", bus.mem_data_in, pat_dead);
        check("wr_addr", DW'(bus.mem_addr), 32'h2000);
        bus.mem_ack      = 1'b1;
        bus.mem_data_out = 128'h1234;
        step();
        check("wr_ack",   DW'(bus.ack), 3'b100);
        check("wr_rdata", bus.rdata, pat_a5);
        bus.mem_ack = 1'b0;
        bus.req     = '0;
        bus.req_rw  = '0;
        step();

        // Fairness: all held, ack one cycle after each enable
        set_addr(0, 32'h100);
        set_addr(1, 32'h200);
        set_addr(2, 32'h300);
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_en",   DW'(bus.mem_enable), 1);
            check("rr_addr", DW'(bus.mem_addr), (k % 3 + 1) * 32'h100);
            bus.mem_ack      = 1'b1;
            bus.mem_data_out = DW'(k + 16'h50);
            step();
            check("rr_ack",   DW'(bus.ack), 3'b001 << (k % 3));
            check("rr_rdata", bus.rdata, DW'(k + 16'h50));
            bus.mem_ack = 1'b0;
            step();
            check("rr_gap", DW'(bus.mem_enable), 0);
        end
        bus.req = '0;

        // mem_ack while idle is ignored
        bus.mem_ack = 1'b1;
        step();
        check("idle_ack", DW'(bus.ack), 0);
        check("idle_en",  DW'(bus.mem_enable), 0);
        bus.mem_ack = 1'b0;

        // Mid-transaction change: address latched, port 1 served next
        bus.req = 3'b001;
        set_addr(0, 32'h3000);
        set_addr(1, 32'h4000);
        step();
        check("mid_addr0", DW'(bus.mem_addr), 32'h3000);
        set_addr(0, 32'h3333);
        bus.req = 3'b011;
        step();
        check("mid_addr_hold", DW'(bus.mem_addr), 32'h3000);
        bus.mem_ack = 1'b1;
        step();
        check("mid_ack0", DW'(bus.ack), 3'b001);
        bus.mem_ack = 1'b0;
        bus.req     = 3'b010;
        step();
        step();
        check("mid_en1",   DW'(bus.mem_enable), 1);
        check("mid_addr1", DW'(bus.mem_addr), 32'h4000);
        bus.mem_ack = 1'b1;
        step();
        check("mid_ack1", DW'(bus.ack), 3'b010);
        bus.mem_ack = 1'b0;
        bus.req     = '0;
        step();

        // Reset in BUSY, then port 0 wins again
        bus.req = 3'b100;
        step();
        check("rst_busy_en", DW'(bus.mem_enable), 1);
        reset = 1'b1;
        #1;
        check("rst_drop_en",   DW'(bus.mem_enable), 0);
        check("rst_drop_ack",  DW'(bus.ack), 0);
        check("rst_drop_addr", DW'(bus.mem_addr), 0);
        bus.req = 3'b111;
        step();
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        check("rst_no_ack",  DW'(bus.ack), 0);
        check("rst_p0_addr", DW'(bus.mem_addr), 32'h3333);
        step();
        check("rst_p0_ack", DW'(bus.ack), 3'b001);
        bus.mem_ack = 1'b0;
        bus.req     = '0;
        step();

`ifdef ARB_TIMEOUT_EN
        // Timeout: port 1 never acked, err 8 edges after entry
        bus.req = 3'b010;
        step();
        check("to_en", DW'(bus.mem_enable), 1);
        for (int k = 0; k < 7; k++) begin
            step();
            check("to_wait_err", DW'(bus.err), 0);
            check("to_wait_en",  DW'(bus.mem_enable), 1);
        end
        bus.req = 3'b110;
        set_addr(2, 32'h5000);
        step();
        check("to_err",   DW'(bus.err), 3'b010);
        check("to_ack",   DW'(bus.ack), 0);
        check("to_en0",   DW'(bus.mem_enable), 0);
        check("to_rdata", bus.rdata, DW'(5 + 16'h50));
        step();
        check("to_err_1cyc", DW'(bus.err), 0);
        step();
        check("to_next_addr", DW'(bus.mem_addr), 32'h5000);
        bus.mem_ack = 1'b1;
        step();
        check("to_next_ack", DW'(bus.ack), 3'b100);
        bus.mem_ack = 1'b0;
        bus.req     = '0;
        step();
`else
        check("err_tied", DW'(bus.err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
